// File: rtl/rgb_ctrl_if.sv
// Request/colour bundle between the status sources and the RGB LED arbiter.
// The master side drives requests, colours and modes; the slave side returns grant and LED drive.
interface rgb_ctrl_if #(
    parameter int nbpc = 8,
    parameter int nreq = 4
);
    logic [nreq-1:0]        req;
    logic [nreq*3*nbpc-1:0] color;
    logic [2*nreq-1:0]      mode;
    logic [nreq-1:0]        grant;
    logic [3*nbpc-1:0]      color_out;
    logic                   led_en;

    modport master (
        output req, color, mode,
        input  grant, color_out, led_en
    );

    modport slave (
        input  req, color, mode,
        output grant, color_out, led_en
    );
endinterface

// File: rtl/rgb_ctrl.sv
// Fixed-priority RGB LED arbiter with a minimum display time and per-requester
// solid / blink / breathe effects; all outputs registered.
module rgb_ctrl #(
    parameter int nbpc       = 8,
    parameter int nreq       = 4,
    parameter int tick_div   = 120000,
    parameter int hold_ticks = 20
) (
    input  logic       clk,
    input  logic       rst,
    rgb_ctrl_if.slave  bus
);
    localparam int CW = 3 * nbpc;
    localparam int PW = 2 * nbpc + 1;
    localparam int OW = (nreq > 1) ? $clog2(nreq) : 1;
    localparam int HW = $clog2(hold_ticks + 1);
    localparam int TW = $clog2(tick_div);

    localparam logic [HW-1:0]   HOLD_MAX = HW'(hold_ticks);
    localparam logic [TW-1:0]   TICK_TOP = TW'(tick_div - 1);
    localparam logic [nbpc-1:0] LVL_MAX  = '1;
    localparam logic [nbpc-1:0] LVL_ONE  = nbpc'(1);

    typedef enum logic {IDLE, SHOW} state_e;
    typedef enum logic [1:0] {M_SOLID = 2'b00, M_BLINK = 2'b01, M_BREATHE = 2'b10, M_RSVD = 2'b11} mode_e;

    state_e           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [3:0]       phase_q, phase_d;
    logic [nbpc-1:0]  level_q, level_d;
    logic             dir_dn_q, dir_dn_d;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [nreq-1:0]  grant_q, grant_d;
    logic [CW-1:0]    color_out_q, color_out_d;
    logic             led_en_q, led_en_d;

    logic             tick;
    logic             preempt;
    logic             restart;
    logic [CW-1:0]    own_col;
    logic [CW-1:0]    breathe_col;
    logic [PW-1:0]    prod;
    mode_e            own_mode;

    function automatic logic [OW-1:0] lowest(input logic [nreq-1:0] v);
        lowest = '0;
        for (int i = nreq - 1; i >= 0; i--)
            if (v[i]) lowest = OW'(i);
    endfunction

    // NOTE: every signal driven here gets a default before any branch, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_d     = hold_q;
        phase_d    = phase_q;
        level_d    = level_q;
        dir_dn_d   = dir_dn_q;
        restart    = 1'b0;
        tick       = (tick_cnt_q == TICK_TOP);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

        preempt = 1'b0;
        for (int i = 0; i < nreq; i++)
            if (bus.req[i] && (OW'(i) < owner_q)) preempt = 1'b1;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = SHOW;
                    owner_d = lowest(bus.req);
                    restart = 1'b1;
                end
            end
            SHOW: begin
                if (preempt) begin
                    owner_d = lowest(bus.req);
                    restart = 1'b1;
                end else if (!bus.req[owner_q] && hold_q == HOLD_MAX) begin
                    if (|bus.req) begin
                        owner_d = lowest(bus.req);
                        restart = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tick) begin
                    if (hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
                    phase_d = phase_q + 4'd1;
                    // Turn around on reaching an endpoint so each endpoint is shown for one tick only.
                    if (!dir_dn_q) begin
                        level_d = level_q + LVL_ONE;
                        if (level_q == LVL_MAX - LVL_ONE) dir_dn_d = 1'b1;
                    end else begin
                        level_d = level_q - LVL_ONE;
                        if (level_q == LVL_ONE) dir_dn_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (restart) begin
            hold_d   = '0;
            phase_d  = '0;
            level_d  = '0;
            dir_dn_d = 1'b0;
        end

        // Outputs are computed from next-state so a req change shows one cycle later.
        own_col  = bus.color[int'(owner_d) * CW +: CW];
        own_mode = mode_e'(bus.mode[int'(owner_d) * 2 +: 2]);

        breathe_col = '0;
        prod        = '0;
        for (int c = 0; c < 3; c++) begin
            prod = PW'(own_col[c * nbpc +: nbpc]) * (PW'(level_d) + PW'(1));
            breathe_col[c * nbpc +: nbpc] = nbpc'(prod >> nbpc);
        end

        grant_d     = '0;
        color_out_d = '0;
        led_en_d    = 1'b0;
        if (state_d == SHOW) begin
            grant_d[owner_d] = 1'b1;
            led_en_d         = 1'b1;
            case (own_mode)
                M_BLINK:   color_out_d = phase_d[3] ? '0 : own_col;
                M_BREATHE: color_out_d = breathe_col;
                default:   color_out_d = own_col;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            hold_q      <= '0;
            phase_q     <= '0;
            level_q     <= '0;
            dir_dn_q    <= 1'b0;
            tick_cnt_q  <= '0;
            grant_q     <= '0;
            color_out_q <= '0;
            led_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            hold_q      <= hold_d;
            phase_q     <= phase_d;
            level_q     <= level_d;
            dir_dn_q    <= dir_dn_d;
            tick_cnt_q  <= tick_cnt_d;
            grant_q     <= grant_d;
            color_out_q <= color_out_d;
            led_en_q    <= led_en_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.color_out = color_out_q;
    assign bus.led_en    = led_en_q;
endmodule

// File: doc/rgb_ctrl.md
# rgb_ctrl

Arbiter and effect sequencer for the on-board RGB LED driver. It shares the single LED between `nreq` status requesters using fixed priority with a minimum display time, so short pulses stay visible. It applies a per-requester effect (solid, blink, breathe) and drives the LED driver's packed colour word and enable. It sits between the status sources (FSM, UART, error flags) and the `rgb` PWM instance.

## Interface
- `nbpc`, default `LED_NBPC` (8): bits per colour channel.
- `nreq`, default 4: number of requesters; index 0 has the highest priority.
- `tick_div`, default 120000: clk cycles per effect tick (10 ms at 12 MHz); must be ≥ 2.
- `hold_ticks`, default 20: minimum ticks a grant is held after the owner drops `req`; must be ≥ 1.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  nreq  per-requester display request, level-sensitive.
- `color`  in  nreq*3*nbpc  packed colours; requester i uses `[(i+1)*3*nbpc-1 : i*3*nbpc]`, ordered R,G,B MSB→LSB, the same packing as the `rgb` `in` port.
- `mode`  in  2*nreq  per-requester effect; 00 solid, 01 blink, 10 breathe, 11 treated as solid.
- `grant`  out  nreq  one-hot current owner; all zero when idle.
- `color_out`  out  3*nbpc  effected colour, connects to `rgb.in`.
- `led_en`  out  1  connects to `rgb.en`.

## Operation
- Tick generator
  - Free-running counter 0..`tick_div`-1.
  - `tick` pulses for one cycle when the counter wraps.
  - The counter is not reset by grant changes.
- States are IDLE and SHOW. The state register holds `owner` (clog2(nreq) bits) and `hold` (saturating tick count, 0..`hold_ticks`).
- IDLE
  - `grant`=0, `led_en`=0, `color_out`=0.
  - If any `req` bit is high, go to SHOW with owner = lowest set index.
- SHOW, evaluated each cycle in this order:
  - **Preempt:** any `req[j]` with j < owner → owner=j. `hold`, phase and breathe state all restart.
  - **Release:** `req[owner]`=0 and `hold`==`hold_ticks` → owner = lowest set index of `req` (with restart), or go to IDLE if `req`=0.
  - **Otherwise:** stay. On `tick`, `hold` increments and saturates.
  - If `req[owner]` re-asserts before release, the grant continues with no restart.
- `hold` counts ticks since the grant was issued, not since `req` fell. A requester held longer than `hold_ticks` therefore releases on the cycle after its `req` falls.
- Effects, all advanced only on `tick`:
  - Phase: 4-bit counter.
  - **Solid:** `color_out` = owner colour.
  - **Blink:** owner colour when phase[3]==0, else 0. This gives 8 ticks on and 8 ticks off.
  - **Breathe:**
    - `level` (nbpc bits) ramps 0→max by +1, then max→0 by −1, and repeats. Each endpoint is held for exactly one tick.
    - Each channel = (ch × (level+1)) >> nbpc, computed at full 2*nbpc+1 width and then truncated.
    - level=max gives ch exactly; level=0 gives 0.
- In SHOW, `led_en`=1 in every mode, including blink-off phases.
- `mode` and `color` are sampled live every cycle. Changing them mid-grant takes effect on the next cycle and does not restart phase.

## Timing
- All outputs are registered.
- A change on `req` is reflected on `grant`, `color_out` and `led_en` one cycle later.
- On restart, phase=0, level=0, direction=up and hold=0 on the same edge that updates `grant`. The first effect output is therefore blink-on and breathe at level 0.
- Reset values:
  - `grant`=0, `color_out`=0, `led_en`=0, state IDLE.
  - Tick counter, `hold`, phase and level all 0.
- Reset mid-grant: all of the above on the next edge. Requests are re-arbitrated in the first cycle after `rst` falls.
- Simultaneous owner release and higher-priority request: the higher-priority requester is granted; there is no IDLE cycle.
- Simultaneous release and `tick` when `hold`==`hold_ticks`-1: release waits until the next cycle, because `hold` saturates first.

## Test plan
Bench parameters: `tick_div`=4, `hold_ticks`=3, `nbpc`=8, `nreq`=4.
- **Reset:** assert `rst` for 2 cycles with `req`=4'b1111 → `grant`=0, `led_en`=0, `color_out`=0 during reset. One cycle after `rst` falls, `grant`=4'b0001.
- **Preemption:** `req`=4'b0100 with colour 0x00FF00, solid → `grant`=0100 and `color_out`=0x00FF00 after 1 cycle. Then assert `req[1]` with colour 0xFF0000 → `grant`=0010 and `color_out`=0xFF0000 on the next cycle.
- **Minimum hold:** `req[2]` pulsed for 1 cycle → `grant`=0100 for exactly 3 ticks (about 12 cycles), then `grant`=0, `led_en`=0.
- **Blink:** requester 0, mode 01, colour 0x123456 → `color_out`=0x123456 for 8 ticks (32 cycles), then 0 for 8 ticks, then repeats; `led_en` stays 1 throughout.
- **Breathe:** mode 10, colour 0xFF8040 → first output 0x000000. At level=255, output is 0xFF8040. At level=127, output is 0x7F4020. Each endpoint holds for one tick, and the full cycle is 510 ticks.
- **Handoff without idle:** owner 1 has `hold` saturated; drop `req[1]` while raising `req[3]` in the same cycle → `grant` goes 0010→1000 with `led_en` never 0.
